// File: rtl/multibyte_add_pkg.sv
// Shared types and helpers for the byte-serial add/subtract sequencer.
package multibyte_add_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed overflow: operands agree in sign but the sum does not.
    function automatic logic calc_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/multibyte_add_sequencer_slice.sv
// One-byte ripple-carry adder; the only arithmetic in the sequencer.
module multibyte_add_sequencer_slice
    import multibyte_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              carry_in,
    output logic [BYTE_W-1:0] sum_c,
    output logic              carry_c
);

    always_comb begin
        logic [BYTE_W:0] chain;
        sum_c    = '0;
        chain    = '0;
        chain[0] = carry_in;
        for (int unsigned i = 0; i < BYTE_W; i++) begin
            sum_c[i]   = a[i] ^ b[i] ^ chain[i];
            chain[i+1] = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
        end
        carry_c = chain[BYTE_W];
    end

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Wide add/subtract executed one byte per clock, LSB first, on a single 8-bit slice.
module multibyte_add_sequencer
    import multibyte_add_pkg::*;
#(
    parameter  int unsigned NUM_BYTES = 4,
    localparam int unsigned W         = BYTE_W * NUM_BYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         sub,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         overflow,
    output logic         zero,
    output logic         busy
);

    localparam int unsigned CNT_W = $clog2(NUM_BYTES + 1);

    state_t            state;
    logic [W-1:0]      a_sr;
    logic [W-1:0]      b_sr;
    logic              carry;
    logic [CNT_W-1:0]  cnt;

    logic [BYTE_W-1:0] slice_sum;
    logic              slice_carry;
    logic [W-1:0]      result_next;
    logic              last_byte;

    multibyte_add_sequencer_slice u_slice (
        .a        (a_sr[BYTE_W-1:0]),
        .b        (b_sr[BYTE_W-1:0]),
        .carry_in (carry),
        .sum_c    (slice_sum),
        .carry_c  (slice_carry)
    );

    // New byte enters at the top; after NUM_BYTES shifts the result is aligned.
    if (NUM_BYTES == 1) begin : g_single
        assign result_next = slice_sum;
    end else begin : g_multi
        assign result_next = {slice_sum, result[W-1:BYTE_W]};
    end

    assign last_byte = (cnt == CNT_W'(NUM_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            a_sr         <= '0;
            b_sr         <= '0;
            carry        <= 1'b0;
            cnt          <= '0;
            result       <= '0;
            carry_out    <= 1'b0;
            overflow     <= 1'b0;
            zero         <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            start_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // Subtract is A + ~B + 1: invert B here and seed the carry with sub.
                    if (start_valid && start_ready) begin
                        a_sr        <= op_a;
                        b_sr        <= sub ? ~op_b : op_b;
                        carry       <= sub;
                        cnt         <= '0;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    result <= result_next;
                    a_sr   <= a_sr >> BYTE_W;
                    b_sr   <= b_sr >> BYTE_W;
                    carry  <= slice_carry;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_byte) begin
                        carry_out    <= slice_carry;
                        overflow     <= calc_overflow(a_sr[BYTE_W-1], b_sr[BYTE_W-1],
                                                      slice_sum[BYTE_W-1]);
                        zero         <= (result_next == '0);
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        start_ready  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
